// File: rtl/hex_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_driver
// Brief    : Multi-digit active-low seven-segment driver; sequential
//            double-dabble for decimal, direct nibble mapping for hex.
// Revision : 1.0
// ============================================================================
module hex_display_driver #(
    parameter int VALUE_W = 16,
    parameter int DIGITS  = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [VALUE_W-1:0]    value_i,
    input  logic                  hex_mode_i,
    input  logic                  blank_lz_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [7*DIGITS-1:0]   hex_out_o
);

    localparam int CNT_W    = $clog2(VALUE_W + 1);
    // Upper bound on decimal digits of 2^VALUE_W-1 (0.302 > log10(2)).
    localparam int DEC_NEED = (VALUE_W * 302) / 1000 + 1;
    localparam int BCD_DIG  = (DIGITS + 1 > DEC_NEED) ? DIGITS + 1 : DEC_NEED;
    localparam int BCD_W    = 4 * BCD_DIG;
    localparam int PAD_W    = (VALUE_W > 4 * DIGITS) ? VALUE_W : 4 * DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [VALUE_W-1:0]    val_q, val_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  hex_q, hex_d;
    logic                  blank_q, blank_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;

    logic [BCD_W-1:0]      w_bcd_adj;
    logic [PAD_W-1:0]      w_val_pad;
    logic                  w_ovf;
    logic                  w_lz;
    logic [3:0]            w_nib;
    logic [7*DIGITS-1:0]   w_seg;

    function automatic logic [6:0] seg_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display image is built from the latched operands and the finished BCD.
    always_comb begin
        w_val_pad = PAD_W'(val_q);
        w_ovf     = hex_q ? |(w_val_pad >> (4 * DIGITS)) : |(bcd_q >> (4 * DIGITS));
        w_lz      = 1'b1;
        w_nib     = 4'd0;
        w_seg     = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nib = hex_q ? w_val_pad[4*i +: 4] : bcd_q[4*i +: 4];
            if (w_nib != 4'd0) begin
                w_lz = 1'b0;
            end
            if (w_ovf) begin
                w_seg[7*i +: 7] = SEG_DASH;
            end else if (blank_q && w_lz && (i != 0)) begin
                w_seg[7*i +: 7] = SEG_BLANK;
            end else begin
                w_seg[7*i +: 7] = seg_font(w_nib);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        seg_d   = seg_q;
        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    val_d   = value_i;
                    hex_d   = hex_mode_i;
                    blank_d = blank_lz_i;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(VALUE_W);
                    state_d = hex_mode_i ? S_UPDATE : S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d = (w_bcd_adj << 1) | BCD_W'(val_q[VALUE_W-1]);
                val_d = val_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                seg_d   = w_seg;
                ovf_d   = w_ovf;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= 1'b0;
            blank_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign hex_out_o  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_driver
// Brief    : Scoreboard bench driving a 6-digit and a 4-digit instance.
// Revision : 1.0
// ============================================================================
module tb_hex_display_driver;

    localparam logic [6:0] L0 = 7'h40, L1 = 7'h79, L2 = 7'h24, L3 = 7'h30;
    localparam logic [6:0] L4 = 7'h19, L5 = 7'h12, L6 = 7'h02, L8 = 7'h00;
    localparam logic [6:0] L9 = 7'h18, LA = 7'h08, LC = 7'h46, LB = 7'h03;
    localparam logic [6:0] LD = 7'h21, LE = 7'h06, LF = 7'h0E;
    localparam logic [6:0] BL = 7'h7F, DS = 7'h3F;

    typedef struct {
        logic [41:0] hex;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset_i;
    logic        load_i;
    logic [15:0] value_i;
    logic        hex_mode_i;
    logic        blank_lz_i;
    logic        busy6, done6, ov6, busy4, done4, ov4;
    logic [41:0] hex6;
    logic [27:0] hex4;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev6  = 1'b0;
    logic prev4  = 1'b0;
    exp_t q6[$];
    exp_t q4[$];

    hex_display_driver #(.VALUE_W(16), .DIGITS(6)) dut6 (
        .clk_i(clk), .reset_i(reset_i), .load_i(load_i), .value_i(value_i),
        .hex_mode_i(hex_mode_i), .blank_lz_i(blank_lz_i), .busy_o(busy6),
        .done_o(done6), .overflow_o(ov6), .hex_out_o(hex6)
    );

    hex_display_driver #(.VALUE_W(16), .DIGITS(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .load_i(load_i), .value_i(value_i),
        .hex_mode_i(hex_mode_i), .blank_lz_i(blank_lz_i), .busy_o(busy4),
        .done_o(done4), .overflow_o(ov4), .hex_out_o(hex4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [41:0] p6(input logic [6:0] a5, a4, a3, a2, a1, a0);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [41:0] p4(input logic [6:0] a3, a2, a1, a0);
        return {14'h0, a3, a2, a1, a0};
    endfunction

    // Monitors: pop an expectation whenever an instance pulses done.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_i && done6) begin
            if (q6.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut6_unexpected_done at cycle %0d", cyc);
            end else begin
                e = q6.pop_front();
                chk("dut6_hex_out", 64'(hex6), 64'(e.hex));
                chk("dut6_overflow", 64'(ov6), 64'(e.ovf));
                chk("dut6_latency", 64'(cyc), 64'(e.due));
                chk("dut6_busy_at_done", 64'(busy6), 64'(0));
                chk("dut6_done_single", 64'(prev6), 64'(0));
            end
        end
        prev6 = done6;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_i && done4) begin
            if (q4.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut4_unexpected_done at cycle %0d", cyc);
            end else begin
                e = q4.pop_front();
                chk("dut4_hex_out", 64'(hex4), 64'(e.hex[27:0]));
                chk("dut4_overflow", 64'(ov4), 64'(e.ovf));
                chk("dut4_latency", 64'(cyc), 64'(e.due));
            end
        end
        prev4 = done4;
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done6) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    // Called at a negedge; load is presented and accepted at the next posedge.
    task automatic issue(input logic [15:0] v, input logic hx, input logic bl,
                         input logic [41:0] e6, input logic o6,
                         input logic [41:0] e4, input logic o4, input int hold);
        exp_t e;
        load_i     = 1'b1;
        value_i    = v;
        hex_mode_i = hx;
        blank_lz_i = bl;
        @(posedge clk);
        #1;
        e.due = cyc + (hx ? 1 : 17);
        e.hex = e6;
        e.ovf = o6;
        q6.push_back(e);
        e.hex = e4;
        e.ovf = o4;
        q4.push_back(e);
        chk("busy_after_load", 64'(busy6), 64'(1));
        value_i    = ~v;
        hex_mode_i = ~hx;
        blank_lz_i = ~bl;
        for (int k = 0; k < hold; k++) @(posedge clk);
        #1 load_i = 1'b0;
        wait_done();
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_hex6_dark"}, 64'(hex6), 64'({42{1'b1}}));
        chk({tag, "_hex4_dark"}, 64'(hex4), 64'({28{1'b1}}));
        chk({tag, "_busy"}, 64'({busy6, busy4}), 64'(0));
        chk({tag, "_done"}, 64'({done6, done4}), 64'(0));
        chk({tag, "_overflow"}, 64'({ov6, ov4}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i    = 1'b0;
        load_i     = 1'b0;
        value_i    = 16'h0;
        hex_mode_i = 1'b0;
        blank_lz_i = 1'b0;
        #2 reset_i = 1'b1;
        #1 chk_dark("reset_async");
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        issue(16'd12345, 1'b0, 1'b1, p6(BL, L1, L2, L3, L4, L5), 1'b0, p4(DS, DS, DS, DS), 1'b1, 0);
        issue(16'hBEEF,  1'b1, 1'b0, p6(L0, L0, LB, LE, LE, LF), 1'b0, p4(LB, LE, LE, LF), 1'b0, 0);
        issue(16'd0,     1'b0, 1'b1, p6(BL, BL, BL, BL, BL, L0), 1'b0, p4(BL, BL, BL, L0), 1'b0, 0);
        issue(16'd10000, 1'b0, 1'b0, p6(L0, L1, L0, L0, L0, L0), 1'b0, p4(DS, DS, DS, DS), 1'b1, 0);
        issue(16'd9999,  1'b0, 1'b0, p6(L0, L0, L9, L9, L9, L9), 1'b0, p4(L9, L9, L9, L9), 1'b0, 0);
        issue(16'd65535, 1'b0, 1'b1, p6(BL, L6, L5, L5, L3, L5), 1'b0, p4(DS, DS, DS, DS), 1'b1, 0);
        issue(16'h00A5,  1'b1, 1'b1, p6(BL, BL, BL, BL, LA, L5), 1'b0, p4(BL, BL, LA, L5), 1'b0, 0);
        issue(16'h1C0D,  1'b1, 1'b1, p6(BL, BL, L1, LC, L0, LD), 1'b0, p4(L1, LC, L0, LD), 1'b0, 0);
        // load stays asserted with a different operand through most of CONVERT
        issue(16'd100,   1'b0, 1'b1, p6(BL, BL, BL, L1, L0, L0), 1'b0, p4(BL, L1, L0, L0), 1'b0, 10);
        issue(16'd9999,  1'b0, 1'b1, p6(BL, BL, L9, L9, L9, L9), 1'b0, p4(L9, L9, L9, L9), 1'b0, 0);

        // Abort a conversion at its fifth cycle.
        load_i     = 1'b1;
        value_i    = 16'd12345;
        hex_mode_i = 1'b0;
        blank_lz_i = 1'b1;
        @(posedge clk);
        #1 load_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_i = 1'b1;
        #1 chk_dark("reset_mid_convert");
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk_dark("after_reset_release");

        issue(16'd42,    1'b0, 1'b1, p6(BL, BL, BL, BL, L4, L2), 1'b0, p4(BL, BL, L4, L2), 1'b0, 0);
        issue(16'h0008,  1'b1, 1'b0, p6(L0, L0, L0, L0, L0, L8), 1'b0, p4(L0, L0, L0, L8), 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("dut6_queue_empty", 64'(q6.size()), 64'(0));
        chk("dut4_queue_empty", 64'(q4.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_driver.md
# hex_display_driver

Parametrised multi-digit seven-segment driver for the HEX display bank. It accepts a binary value on a one-cycle `load` strobe and renders it across `DIGITS` active-low seven-segment outputs. Decimal mode uses a sequential double-dabble converter; hex mode is a direct nibble mapping. Optional leading-zero blanking and overflow indication are provided. It sits between the game logic (score, lives, level counters) and the board HEX pins, and replaces per-digit combinational decoders.

## Interface
- `VALUE_W`, 16: width of the binary input value.
- `DIGITS`, 6: number of seven-segment digits driven, digit 0 least significant.
- `clk`  input  1  system clock; the block has one clock.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  one-cycle strobe; samples `value`, `hex_mode` and `blank_lz`. Accepted only in IDLE.
- `value`  input  VALUE_W  binary value to display.
- `hex_mode`  input  1  1 = hexadecimal digits, 0 = decimal (BCD).
- `blank_lz`  input  1  1 = blank leading zeros; digit 0 is always shown.
- `busy`  output  1  high while state is not IDLE.
- `done`  output  1  one-cycle pulse after the display registers update.
- `overflow`  output  1  registered; set when the last rendered value did not fit in `DIGITS` digits.
- `hex_out`  output  7*DIGITS  active-low segments; bits [7i+6:7i] drive digit i, with bit 0 = segment a through bit 6 = segment g.

## Operation
- Font, as 7-bit active-low codes g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank=7F, dash=3F.
- State machine: IDLE, CONVERT, UPDATE.
  - IDLE + `load` + decimal: latch operands, clear the BCD register, go to CONVERT.
  - IDLE + `load` + hex: latch operands, go to UPDATE.
  - CONVERT: exactly VALUE_W cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left 1 with the next value MSB in. A bit counter of width clog2(VALUE_W+1) counts down to 0, then the state goes to UPDATE.
  - UPDATE: one cycle. Registers `hex_out` and `overflow`, pulses `done`, returns to IDLE.
- BCD register width is 4*(DIGITS+1). The extra top digit must be wide enough that no conversion truncates.
- Decimal overflow: any nonzero BCD digit at index ≥ DIGITS.
- Hex overflow: any `value` bit at index ≥ 4*DIGITS is nonzero.
- On overflow, every digit shows dash (3F) and `overflow`=1. Otherwise `overflow`=0.
- Blanking, when `blank_lz`=1: digit i>0 is blank (7F) if it and all higher digits are zero. No blanking is applied on overflow.
- `load` outside IDLE is ignored; no queuing. `hex_out` holds its previous contents until UPDATE.
- Operand inputs are sampled only at load acceptance; later changes have no effect.

## Timing
- Reset (async assert, any state): state=IDLE, `busy`=0, `done`=0, `overflow`=0, `hex_out`=all 7F (display dark), counters and BCD register cleared.
- Reset mid-conversion aborts it. The display returns to dark, not to the prior value.
- Decimal latency:
  - `load` accepted at edge E0.
  - CONVERT occupies the cycles after edges E1..E(VALUE_W).
  - `hex_out`/`overflow` update at edge E(VALUE_W+1), with `done` high for the following cycle.
  - `busy` is high from E0 until E(VALUE_W+1).
- Hex latency: accepted at E0; `hex_out` updates at E1, with `done` high for the following cycle.
- `load` in the same cycle as `done` (state IDLE) is accepted. Back-to-back decimal throughput is one value per VALUE_W+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: assert `reset` asynchronously with no clock edge.
  - Response: `hex_out` all 7F, `busy`=0, `done`=0, `overflow`=0, immediately.
- Decimal 12345, defaults, `blank_lz`=1:
  - Response: after 18 edges, digits 5..0 = 7F,79,24,30,19,12; `done` for one cycle; `overflow`=0.
- Hex 0xBEEF, `blank_lz`=0:
  - Response: at E1, digits 5..0 = 40,40,03,06,06,0E.
- Value 0, decimal, `blank_lz`=1:
  - Response: digit 0 = 40, digits 5..1 = 7F.
- DIGITS=4, decimal 10000 (overflow):
  - Response: all digits 3F, `overflow`=1.
  - Follow-up: then load 9999 → digits 18,18,18,18, `overflow`=0.
- `load` held during CONVERT with a different value:
  - Response: ignored; the original value is displayed.
- Reset pulse at CONVERT cycle 5:
  - Response: display dark, `busy`=0.
  - Follow-up: a subsequent load of 42 shows 7F,7F,7F,7F,19,24.
